// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - assembles UART bytes into RGB pixels and writes them to a frame buffer
module uart_frame_loader #(
    parameter int H_RES          = 320,
    parameter int V_RES          = 240,
    parameter int ADDR_WIDTH     = 17,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic                  rx_ready,
    input  logic [7:0]            rx_data,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [23:0]           fb_wdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout_err,
    output logic                  overrun_err
);

    localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TERM_CNT  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_R, WAIT_G, WAIT_B, WRITE, FRAME_DONE
    } state_t;

    state_t                 state, state_nx;
    logic [7:0]             r_q, r_nx, g_q, g_nx, b_q, b_nx;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_nx;
    logic [ADDR_WIDTH-1:0]  addr_nx;
    logic [23:0]            wdata_nx;
    logic                   we_nx, done_nx, tmo_err_nx, ovr_nx;

    assign busy = (state != IDLE);

    always_comb begin
        state_nx   = state;
        r_nx       = r_q;
        g_nx       = g_q;
        b_nx       = b_q;
        tmo_nx     = tmo_q;
        addr_nx    = fb_addr;
        wdata_nx   = fb_wdata;
        we_nx      = 1'b0;
        done_nx    = 1'b0;
        tmo_err_nx = 1'b0;
        ovr_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (load_en) begin
                    state_nx = WAIT_R;
                    addr_nx  = '0;
                    tmo_nx   = '0;
                end
            end
            WAIT_R: begin
                if (!load_en) begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                end else if (rx_ready) begin
                    r_nx     = rx_data;
                    tmo_nx   = '0;
                    state_nx = WAIT_G;
                end
            end
            WAIT_G: begin
                if (!load_en) begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                end else if (rx_ready) begin
                    g_nx     = rx_data;
                    tmo_nx   = '0;
                    state_nx = WAIT_B;
                end else if (tmo_q == TERM_CNT) begin
                    tmo_err_nx = 1'b1;
                    tmo_nx     = '0;
                    state_nx   = WAIT_R;
                end else begin
                    tmo_nx = tmo_q + 1'b1;
                end
            end
            WAIT_B: begin
                if (!load_en) begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                end else if (rx_ready) begin
                    b_nx     = rx_data;
                    wdata_nx = {r_q, g_q, rx_data};
                    we_nx    = 1'b1;
                    tmo_nx   = '0;
                    state_nx = WRITE;
                end else if (tmo_q == TERM_CNT) begin
                    tmo_err_nx = 1'b1;
                    tmo_nx     = '0;
                    state_nx   = WAIT_R;
                end else begin
                    tmo_nx = tmo_q + 1'b1;
                end
            end
            WRITE: begin
                // a byte arriving while the pixel is being stored has nowhere to go
                ovr_nx = rx_ready;
                tmo_nx = '0;
                if (fb_addr == LAST_ADDR) begin
                    done_nx  = 1'b1;
                    addr_nx  = '0;
                    state_nx = FRAME_DONE;
                end else if (load_en) begin
                    addr_nx  = fb_addr + ADDR_WIDTH'(1);
                    state_nx = WAIT_R;
                end else begin
                    addr_nx  = '0;
                    state_nx = IDLE;
                end
            end
            FRAME_DONE: begin
                ovr_nx   = rx_ready;
                tmo_nx   = '0;
                state_nx = load_en ? WAIT_R : IDLE;
            end
            default: begin
                state_nx = IDLE;
                addr_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            tmo_q       <= '0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            fb_we       <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_nx;
            r_q         <= r_nx;
            g_q         <= g_nx;
            b_q         <= b_nx;
            tmo_q       <= tmo_nx;
            fb_addr     <= addr_nx;
            fb_wdata    <= wdata_nx;
            fb_we       <= we_nx;
            frame_done  <= done_nx;
            timeout_err <= tmo_err_nx;
            overrun_err <= ovr_nx;
        end
    end

    logic unused_b;
    assign unused_b = ^b_q;

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Controller that sequences the UART receive byte stream into whole RGB pixels and writes them into a frame-buffer memory, one frame at a time.
- Sits between the UART receiver's one-cycle `rx_ready`/`rx_data` byte interface and a simple single-port BRAM write port.
- Owns pixel byte ordering (R, G, B), frame-buffer address generation and wrap, and inter-byte timeout resynchronisation.
- Reports frame completion and error conditions to the top level.

Parameters:
H_RES, 320, pixels per line
V_RES, 240, lines per frame
ADDR_WIDTH, 17, frame-buffer address width; must satisfy 2^ADDR_WIDTH >= H_RES*V_RES
TIMEOUT_CYCLES, 1000000, clock cycles allowed between bytes of one pixel (10 ms at 100 MHz)
TIMEOUT_WIDTH, 20, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clock  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset
load_en  input  1  level; high arms frame loading, low aborts/idles
rx_ready  input  1  one-cycle pulse; rx_data valid this cycle
rx_data  input  8  received byte
fb_we  output  1  frame-buffer write strobe, one cycle per pixel
fb_addr  output  ADDR_WIDTH  frame-buffer write address
fb_wdata  output  24  pixel {R,G,B}, R in [23:16]
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse after last pixel of a frame is written
timeout_err  output  1  one-cycle pulse when a partial pixel is discarded by timeout
overrun_err  output  1  one-cycle pulse when rx_ready arrives in WRITE or FRAME_DONE (byte dropped)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - fb_addr=0, fb_wdata=0, all R/G/B holding registers=0, timeout counter=0.
  - fb_we, busy, frame_done, timeout_err, overrun_err all 0.
- States: IDLE, WAIT_R, WAIT_G, WAIT_B, WRITE, FRAME_DONE. All outputs are registered except busy (decoded from state).
- IDLE:
  - load_en=1 -> WAIT_R next cycle, with fb_addr=0.
  - rx_ready in IDLE is ignored silently.
- WAIT_R: rx_ready=1 -> capture rx_data as R on the same edge -> WAIT_G.
- WAIT_G: rx_ready=1 -> capture G -> WAIT_B.
- WAIT_B: rx_ready=1 -> capture B -> WRITE.
- WRITE (exactly one cycle):
  - fb_we=1, fb_addr=current pixel index, fb_wdata={R,G,B}.
  - Latency: fb_we asserts on the cycle immediately after the cycle where the blue rx_ready was high.
  - If fb_addr == H_RES*V_RES-1 -> FRAME_DONE.
  - Otherwise fb_addr increments by 1 (effective after the write cycle) -> WAIT_R.
- FRAME_DONE (one cycle):
  - frame_done=1; fb_addr returns to 0.
  - Next state is WAIT_R if load_en=1 (continuous frames), otherwise IDLE.
- Timeout:
  - The counter clears on every accepted byte and on entry to WAIT_R.
  - It increments each cycle in WAIT_G and WAIT_B.
  - When it reaches TIMEOUT_CYCLES-1 and no rx_ready arrives that cycle: timeout_err pulses, the partial pixel is discarded, state -> WAIT_R, fb_addr unchanged.
  - Rationale: the next byte is treated as R of the same pixel.
  - No timeout in WAIT_R (an arbitrarily long gap between pixels is legal).
- Simultaneous rx_ready and timeout terminal count: the byte is accepted; no timeout.
- load_en=0:
  - In WAIT_R/WAIT_G/WAIT_B: -> IDLE next cycle, partial pixel discarded, fb_addr=0. A coincident rx_ready is ignored.
  - In WRITE: the write completes, then IDLE (no frame_done unless the last pixel).
  - In FRAME_DONE: frame_done still pulses, then IDLE.
- rx_ready in WRITE or FRAME_DONE: byte dropped, overrun_err pulses the following cycle, state flow unaffected.
- fb_wdata holds its last written value outside WRITE.
- fb_we is never high for more than one consecutive cycle.
- fb_addr never exceeds H_RES*V_RES-1.

Test Plan:
1. Bench parameters: H_RES=4, V_RES=2, TIMEOUT_CYCLES=100. Reset low 3 cycles then high; load_en=1.
   - Send bytes 0x11,0x22,0x33 (rx_ready pulses 20 cycles apart).
   - Required: exactly one fb_we pulse, fb_addr=0, fb_wdata=0x112233, one cycle after the 3rd pulse.
2. Send 24 bytes (8 pixels, byte k = k).
   - Required: 8 writes at addresses 0..7 with data 0x000102..0x151617.
   - frame_done pulses once, on the cycle after the address-7 write.
   - Next pixel writes to address 0.
3. Send 0xAA,0xBB, then no byte for 100 cycles, then 0x01,0x02,0x03.
   - Required: timeout_err pulses once, no write of 0xAABB.., and the write at the same address carries 0x010203.
4. rx_ready on the exact terminal-count cycle of the timeout in WAIT_B.
   - Required: no timeout_err, and the pixel is written.
5. Drop load_en after 0x44,0x55 at fb_addr=3.
   - Required: busy falls the next cycle, no fb_we.
   - Re-arm and send 0x66,0x77,0x88: written at address 0.
6. Force rx_ready during the WRITE cycle.
   - Required: overrun_err pulses once, the byte is not captured, and the next pixel is assembled from the following three bytes.
7. Assert reset mid-pixel (in WAIT_G).
   - Required: all outputs 0 asynchronously, state IDLE, no write after release until load_en and three new bytes arrive.
